led_run_ctrl: RTL and testbench

LED_RUN_CTRL -- requirements
Module: led_run_ctrl

---
 rtl/led_pkg.sv | 13 +
 rtl/led_tick_gen.sv | 33 +++
 rtl/led_run_ctrl.sv | 122 ++++++++++++
 tb/tb_led_run_ctrl.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/led_pkg.sv
// Shared LED-block definitions: pattern mode encodings and the PWM dimmer counter width.
package led_pkg;

    typedef enum logic [1:0] {
        MODE_RUN_L    = 2'b00,
        MODE_RUN_R    = 2'b01,
        MODE_PINGPONG = 2'b10,
        MODE_BLINK    = 2'b11
    } mode_e;

    localparam int PWM_W = 4;

endpackage

// File: rtl/led_tick_gen.sv
// Step prescaler for LED blocks: counts 0..TICK_DIV-1 while enabled and not paused,
// and asserts Tick in the cycle the counter wraps.
module led_tick_gen #(
    parameter int TICK_DIV = 20
) (
    input  logic CLK,
    input  logic RSTn,
    input  logic En,
    input  logic Pause,
    output logic Tick
);

    localparam int            CW   = $clog2(TICK_DIV);
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] r_cnt;
    logic          w_last;

    assign w_last = (r_cnt == LAST);
    assign Tick   = En && !Pause && w_last;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_cnt <= '0;
        end else if (!En) begin
            r_cnt <= '0;
        end else if (!Pause) begin
            r_cnt <= w_last ? '0 : r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/led_run_ctrl.sv
// LED running-light controller: run-left, run-right, ping-pong and all-blink patterns stepped by a prescaler.
// Optional macro LED_RUN_PWM_DIM_EN adds a Duty input and a 4-bit PWM dimmer on LED_Out.
module led_run_ctrl
    import led_pkg::*;
#(
    parameter int N_LED    = 4,
    parameter int TICK_DIV = 20
) (
    input  logic             CLK,
    input  logic             RSTn,
    input  logic             En,
    input  logic             Pause,
    input  logic [1:0]       Mode,
`ifdef LED_RUN_PWM_DIM_EN
    input  logic [PWM_W-1:0] Duty,
`endif
    output logic [N_LED-1:0] LED_Out,
    output logic             Step_Pulse
);

    localparam int            PW      = (N_LED > 1) ? $clog2(N_LED) : 1;
    localparam logic [PW-1:0] POS_MAX = PW'(N_LED - 1);

    logic             w_tick;
    mode_e            w_mode;
    logic [PW-1:0]    r_pos, w_pos_d;
    logic             r_dir, w_dir_d;
    logic             r_blink, w_blink_d;
    logic             r_active;
    logic [N_LED-1:0] r_pat, w_pat_d;
    logic             r_step;

    led_tick_gen #(
        .TICK_DIV(TICK_DIV)
    ) u_tick_gen (
        .CLK  (CLK),
        .RSTn (RSTn),
        .En   (En),
        .Pause(Pause),
        .Tick (w_tick)
    );

    assign w_mode = mode_e'(Mode);

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        w_pos_d   = r_pos;
        w_dir_d   = r_dir;
        w_blink_d = r_blink;
        w_pat_d   = r_pat;
        if (!En) begin
            w_pos_d   = '0;
            w_dir_d   = 1'b0;
            w_blink_d = 1'b0;
            w_pat_d   = '0;
        end else if (!r_active) begin
            // First enabled cycle shows the start position without stepping.
            w_pat_d = (w_mode == MODE_BLINK) ? '0 : N_LED'(1);
        end else if (w_tick) begin
            case (w_mode)
                MODE_RUN_L: w_pos_d = (r_pos == POS_MAX) ? '0 : r_pos + 1'b1;
                MODE_RUN_R: w_pos_d = (r_pos == '0) ? POS_MAX : r_pos - 1'b1;
                MODE_PINGPONG: begin
                    if (N_LED == 1) begin
                        w_pos_d = '0;
                    end else if (!r_dir) begin
                        w_dir_d = (r_pos == POS_MAX);
                        w_pos_d = (r_pos == POS_MAX) ? r_pos - 1'b1 : r_pos + 1'b1;
                    end else begin
                        w_dir_d = (r_pos != '0);
                        w_pos_d = (r_pos == '0) ? r_pos + 1'b1 : r_pos - 1'b1;
                    end
                end
                default: w_blink_d = !r_blink;
            endcase
            w_pat_d = (w_mode == MODE_BLINK) ? {N_LED{w_blink_d}} : (N_LED'(1) << w_pos_d);
        end
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_pos    <= '0;
            r_dir    <= 1'b0;
            r_blink  <= 1'b0;
            r_active <= 1'b0;
            r_pat    <= '0;
            r_step   <= 1'b0;
        end else begin
            r_pos    <= w_pos_d;
            r_dir    <= w_dir_d;
            r_blink  <= w_blink_d;
            r_active <= En;
            r_pat    <= w_pat_d;
            r_step   <= w_tick;
        end
    end

`ifdef LED_RUN_PWM_DIM_EN
    logic [PWM_W-1:0] r_pwm, w_pwm_d;
    logic [N_LED-1:0] r_led;

    assign w_pwm_d = r_pwm + 1'b1;

    // Mask the next pattern with the next PWM phase so LED_Out stays a plain register with no added latency.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_pwm <= '0;
            r_led <= '0;
        end else begin
            r_pwm <= w_pwm_d;
            r_led <= w_pat_d & {N_LED{w_pwm_d < Duty}};
        end
    end

    assign LED_Out = r_led;
`else
    assign LED_Out = r_pat;
`endif

    assign Step_Pulse = r_step;

endmodule

// File: tb/tb_led_run_ctrl.sv
// Scoreboard bench for led_run_ctrl (N_LED=4, TICK_DIV=4): a cycle-level reference model pushes the
// expected LED_Out/Step_Pulse for every cycle and an independent monitor pops and compares them.
module tb_led_run_ctrl;
    import led_pkg::*;

    localparam int N  = 4;
    localparam int TD = 4;

    typedef struct packed {
        logic [N-1:0] led;
        logic         step;
    } exp_t;

    logic         CLK   = 1'b0;
    logic         RSTn  = 1'b1;
    logic         En    = 1'b0;
    logic         Pause = 1'b0;
    logic [1:0]   Mode  = 2'b00;
    logic [N-1:0] LED_Out;
    logic         Step_Pulse;
`ifdef LED_RUN_PWM_DIM_EN
    logic [3:0]   Duty  = 4'd4;
`endif

    exp_t         sb_q[$];
    logic [N-1:0] step_log[$];
    int           checks   = 0;
    int           failures = 0;

    // Reference model state: position, bounce direction, blink phase, prescaler phase, PWM phase.
    int           m_active = 0, m_cnt = 0, m_pos = 0, m_dir = 0, m_blink = 0, m_p = 0;
    logic [N-1:0] m_pat    = '0;
    logic         m_step   = 1'b0;

    led_run_ctrl #(
        .N_LED   (N),
        .TICK_DIV(TD)
    ) dut (
        .CLK       (CLK),
        .RSTn      (RSTn),
        .En        (En),
        .Pause     (Pause),
        .Mode      (Mode),
`ifdef LED_RUN_PWM_DIM_EN
        .Duty      (Duty),
`endif
        .LED_Out   (LED_Out),
        .Step_Pulse(Step_Pulse)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [N-1:0] onehot(input int p);
        logic [N-1:0] v;
        v    = '0;
        v[p] = 1'b1;
        return v;
    endfunction

    // One clock edge of the specified behaviour, given the inputs present at that edge.
    task automatic model_edge(input logic rst_s, input logic en_s, input logic pause_s, input logic [1:0] mode_s);
        bit tick;
        int k;
        int period;
        period = 2 * N - 2;
        m_p    = rst_s ? (m_p + 1) % 16 : 0;
        if (!rst_s || !en_s) begin
            m_active = 0; m_cnt = 0; m_pos = 0; m_dir = 0; m_blink = 0;
            m_pat    = '0;
            m_step   = 1'b0;
        end else begin
            m_step = 1'b0;
            if (m_active == 0) begin
                m_active = 1;
                m_pat    = (mode_s == 2'b11) ? '0 : onehot(0);
            end
            tick = !pause_s && (m_cnt == TD - 1);
            if (!pause_s) m_cnt = (m_cnt + 1) % TD;
            if (tick) begin
                m_step = 1'b1;
                case (mode_s)
                    2'b00: m_pos = (m_pos + 1) % N;
                    2'b01: m_pos = (m_pos + N - 1) % N;
                    2'b10: begin
                        // Ping-pong as a phase k on a cycle of 2N-2 positions: 0..N-1 going up, back down.
                        k     = (m_dir != 0 && m_pos != 0) ? period - m_pos : m_pos;
                        k     = (k + 1) % period;
                        m_pos = (k < N) ? k : period - k;
                        m_dir = (k >= N || k == 0) ? 1 : 0;
                    end
                    default: m_blink = 1 - m_blink;
                endcase
                m_pat = (mode_s == 2'b11) ? ((m_blink != 0) ? '1 : '0) : onehot(m_pos);
            end
        end
    endtask

    task automatic push_expected();
        exp_t         e;
        logic [N-1:0] mask;
        mask = '1;
`ifdef LED_RUN_PWM_DIM_EN
        mask = (m_p < int'(Duty)) ? '1 : '0;
`endif
        e.led  = m_pat & mask;
        e.step = m_step;
        sb_q.push_back(e);
    endtask

    // Evaluate the edge just taken, then drive the inputs for the next edge.
    task automatic cycle(input logic rst_n, input logic en, input logic pause, input logic [1:0] mode);
        @(posedge CLK);
        #2;
        model_edge(RSTn, En, Pause, Mode);
        push_expected();
        RSTn  = rst_n;
        En    = en;
        Pause = pause;
        Mode  = mode;
    endtask

    // Called right after cycle(): pulls RSTn low between edges and checks the outputs clear at once.
    task automatic reset_pulse();
        #4 RSTn = 1'b0;
        #1;
        check("async_rst_led", 32'(LED_Out), 32'd0);
        check("async_rst_step", 32'(Step_Pulse), 32'd0);
        @(posedge CLK);
        #2;
        model_edge(RSTn, En, Pause, Mode);
        push_expected();
        RSTn = 1'b1;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge CLK);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check("led_out", 32'(LED_Out), 32'(e.led));
                check("step_pulse", 32'(Step_Pulse), 32'(e.step));
                if (Step_Pulse) step_log.push_back(LED_Out);
            end
        end
    end

    initial begin : stimulus
        logic [N-1:0] pp_exp [8];
        logic [1:0]   r_mode;
        logic         r_en, r_pause;
        pp_exp = '{4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0010, 4'b0100};

        #1 RSTn = 1'b0;
        #2;
        check("reset_led", 32'(LED_Out), 32'd0);
        check("reset_step", 32'(Step_Pulse), 32'd0);
        repeat (2) cycle(1'b0, 1'b0, 1'b0, 2'b00);

        // Run-left from reset.
        repeat (20) cycle(1'b1, 1'b1, 1'b0, 2'b00);

        // Ping-pong from a fresh enable, with the step sequence also checked against a fixed table.
        repeat (3) cycle(1'b1, 1'b0, 1'b0, 2'b10);
        step_log.delete();
        repeat (34) cycle(1'b1, 1'b1, 1'b0, 2'b10);
        cycle(1'b1, 1'b0, 1'b0, 2'b10);
`ifndef LED_RUN_PWM_DIM_EN
        check("pp_step_count", 32'(step_log.size()), 32'd8);
        for (int i = 0; i < 8; i++) begin
            if (i < step_log.size()) check("pp_step_seq", 32'(step_log[i]), 32'(pp_exp[i]));
        end
`endif

        // Run-right, then switch to all-blink between ticks.
        repeat (2) cycle(1'b1, 1'b0, 1'b0, 2'b01);
        repeat (17) cycle(1'b1, 1'b1, 1'b0, 2'b01);
        for (int i = 0; i < 8 && m_cnt != 1; i++) cycle(1'b1, 1'b1, 1'b0, 2'b01);
        Mode = 2'b11;
        repeat (14) cycle(1'b1, 1'b1, 1'b0, 2'b11);

        // Back to run-left: resumes from the held position.
        repeat (10) cycle(1'b1, 1'b1, 1'b0, 2'b00);

        // Pause while 0100 is shown, landing exactly on a tick cycle.
        for (int i = 0; i < 40 && !(m_pat == 4'b0100 && m_cnt == TD - 1); i++) cycle(1'b1, 1'b1, 1'b0, 2'b00);
        Pause = 1'b1;
        repeat (10) cycle(1'b1, 1'b1, 1'b1, 2'b00);
        repeat (12) cycle(1'b1, 1'b1, 1'b0, 2'b00);

        // Asynchronous reset mid-interval with 1000 shown, then restart.
        for (int i = 0; i < 40 && !(m_pat == 4'b1000 && m_cnt == 1); i++) cycle(1'b1, 1'b1, 1'b0, 2'b00);
        reset_pulse();
        repeat (20) cycle(1'b1, 1'b1, 1'b0, 2'b00);

        // Randomised traffic on all inputs.
        r_mode = 2'b00;
        for (int i = 0; i < 600; i++) begin
            r_en    = ($urandom_range(0, 99) < 97);
            r_pause = ($urandom_range(0, 99) < 15);
            if ($urandom_range(0, 99) < 10) r_mode = 2'($urandom_range(0, 3));
            cycle(1'b1, r_en, r_pause, r_mode);
            if ($urandom_range(0, 199) == 0) reset_pulse();
        end

        repeat (2) cycle(1'b1, 1'b0, 1'b0, 2'b00);
        @(negedge CLK);
        #1;
        check("sb_drain", 32'(sb_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
